// File: rtl/multi_tick_gen.sv
// multi_tick_gen
//   Multi-channel timebase generator. Each channel divides clk by a
//   run-time programmable period and produces a one-cycle tick strobe at
//   the end of every period plus a near-50% square wave (low floor(per/2)
//   cycles, then high ceil(per/2) cycles). Period changes are staged in a
//   shadow register and take effect only at a period boundary, or at once
//   on an idle (period 0) channel or on sync_clr.
//
// Ports
//   clk       in   system clock
//   n_rst     in   synchronous active-low reset
//   sync_clr  in   restart all channels in phase (also applies pending loads)
//   ch_en     in   [NCH]       per-channel run enable, 0 pauses the channel
//   ld        in   [NCH]       per-channel load strobe for div
//   div       in   [NCH*DIVW]  requested period, channel i at [i*DIVW +: DIVW]
//   tick      out  [NCH]       one-cycle strobe in the last cycle of a period
//   sq        out  [NCH]       square wave, toggles twice per period
//   pend      out  [NCH]       a loaded period is waiting to take effect
module multi_tick_gen #(
    parameter int unsigned FREQ = 50 * 10**6,
    parameter int unsigned NCH  = 4,
    parameter int unsigned DIVW = $clog2(FREQ + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                sync_clr,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH-1:0]      ld,
    input  logic [NCH*DIVW-1:0] div,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      sq,
    output logic [NCH-1:0]      pend
);

    localparam logic [DIVW-1:0] PER_RST = DIVW'(FREQ);

    logic [DIVW-1:0] r_cnt [NCH];
    logic [DIVW-1:0] r_per [NCH];
    logic [DIVW-1:0] r_shd [NCH];
    logic [NCH-1:0]  r_sq;
    logic [NCH-1:0]  r_pend;

    logic [DIVW-1:0] w_last [NCH];
    logic [DIVW-1:0] w_half [NCH];
    logic [NCH-1:0]  w_idle;
    logic [NCH-1:0]  w_wrap;
    logic [NCH-1:0]  w_tog;
    logic [NCH-1:0]  w_sw;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            w_last[i] = r_per[i] - 1'b1;
            w_half[i] = r_per[i] >> 1;
            w_idle[i] = (r_per[i] == '0);
            // Idle is excluded first so the wrapped-around per-1 never matches.
            w_wrap[i] = ch_en[i] && !w_idle[i] && (r_cnt[i] == w_last[i]);
            // per>=2 is equivalent to per>>1 being non-zero; below that sq holds.
            w_tog[i]  = ch_en[i] && (w_half[i] != '0) &&
                        ((r_cnt[i] == (w_half[i] - 1'b1)) || (r_cnt[i] == w_last[i]));
            // Shadow is applied only at a boundary so the running period completes.
            w_sw[i]   = r_pend[i] && (w_wrap[i] || w_idle[i]);
        end
    end

    // Tick is suppressed while reset or sync_clr is being applied.
    assign tick = w_wrap & {NCH{n_rst & ~sync_clr}};
    assign sq   = r_sq;
    assign pend = r_pend;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!n_rst) begin
                r_cnt[i]  <= '0;
                r_per[i]  <= PER_RST;
                r_shd[i]  <= PER_RST;
                r_pend[i] <= 1'b0;
                r_sq[i]   <= 1'b0;
            end else if (sync_clr) begin
                r_cnt[i] <= '0;
                r_sq[i]  <= 1'b0;
                if (ld[i]) begin
                    // A load coinciding with the clear bypasses the shadow.
                    r_per[i]  <= div[i*DIVW +: DIVW];
                    r_shd[i]  <= div[i*DIVW +: DIVW];
                    r_pend[i] <= 1'b0;
                end else if (r_pend[i]) begin
                    r_per[i]  <= r_shd[i];
                    r_pend[i] <= 1'b0;
                end
            end else begin
                if (w_sw[i]) begin
                    r_per[i]  <= r_shd[i];
                    r_pend[i] <= 1'b0;
                end
                if (w_idle[i] || w_wrap[i]) begin
                    r_cnt[i] <= '0;
                end else if (ch_en[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                if (w_idle[i]) begin
                    r_sq[i] <= 1'b0;
                end else if (w_tog[i]) begin
                    r_sq[i] <= ~r_sq[i];
                end
                // A load in the switch cycle lands in the shadow and stays pending;
                // the switch above already used the old shadow value.
                if (ld[i]) begin
                    r_shd[i]  <= div[i*DIVW +: DIVW];
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
module tb_multi_tick_gen;

    logic       clk;
    logic       n_rst;
    logic       sync_clr;
    logic [1:0] ch_en;
    logic [1:0] ld;
    logic [7:0] div;
    logic [1:0] tick;
    logic [1:0] sq;
    logic [1:0] pend;

    int cyc;
    int n_checks;
    int n_errors;

    multi_tick_gen #(
        .FREQ(8),
        .NCH (2),
        .DIVW(4)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .sync_clr(sync_clr),
        .ch_en   (ch_en),
        .ld      (ld),
        .div     (div),
        .tick    (tick),
        .sq      (sq),
        .pend    (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge and
    // outputs are checked 2 time units after the edge.
    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        n_rst    = 1'b0;
        sync_clr = 1'b0;
        ch_en    = 2'b11;
        ld       = 2'b00;
        div      = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        #1;
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_sq",   32'(sq),   32'd0);
        check_val("rst_pend", 32'(pend), 32'd0);
        n_rst = 1'b1;
        cyc   = 0;

        // Free-running period 8 on both channels.
        while (cyc <= 23) begin
            #1;
            check_val("run_tick", 32'(tick), 32'({2{(cyc % 8) == 7}}));
            check_val("run_sq",   32'(sq),   32'({2{(cyc % 8) >= 4}}));
            check_val("run_pend", 32'(pend), 32'd0);
            adv();
        end

        // Load period 3 into ch0 at cnt=3; current period must complete.
        while (cyc < 27) adv();
        ld  = 2'b01;
        div = 8'h03;
        adv();
        ld  = 2'b00;
        while (cyc <= 39) begin
            #1;
            check_val("ld3_tick0", 32'(tick[0]),
                      32'((cyc == 31) || (cyc >= 32 && ((cyc - 32) % 3) == 2)));
            check_val("ld3_sq0",   32'(sq[0]),
                      32'((cyc <= 31) || (((cyc - 32) % 3) != 0)));
            check_val("ld3_pend0", 32'(pend[0]), 32'(cyc < 32));
            adv();
        end

        // Pause ch1 for 5 cycles starting at cnt=5 (cycles 45..49).
        while (cyc <= 52) begin
            ch_en = (cyc >= 45 && cyc < 50) ? 2'b01 : 2'b11;
            #1;
            check_val("pause_tick1", 32'(tick[1]), 32'(cyc == 52));
            check_val("pause_sq1",   32'(sq[1]),   32'(cyc >= 44));
            adv();
        end
        ch_en = 2'b11;

        // Load period 0 into ch1: idles after the current period.
        ld  = 2'b10;
        div = 8'h00;
        #1;
        check_val("idle_sq1_start", 32'(sq[1]), 32'd0);
        adv();
        ld = 2'b00;
        while (cyc <= 62) begin
            #1;
            check_val("idle_tick1", 32'(tick[1]), 32'(cyc == 60));
            check_val("idle_sq1",   32'(sq[1]),   32'(cyc >= 57 && cyc <= 60));
            check_val("idle_pend1", 32'(pend[1]), 32'(cyc <= 60));
            adv();
        end

        // Load period 1 into the idle ch1: accepted at the next edge.
        ld  = 2'b10;
        div = 8'h10;
        #1;
        check_val("p1_tick1_ld", 32'(tick[1]), 32'd0);
        adv();
        ld = 2'b00;
        #1;
        check_val("p1_pend1", 32'(pend[1]), 32'd1);
        check_val("p1_tick1_wait", 32'(tick[1]), 32'd0);
        adv();
        while (cyc <= 68) begin
            #1;
            check_val("p1_tick1", 32'(tick[1]), 32'd1);
            check_val("p1_sq1",   32'(sq[1]),   32'd0);
            check_val("p1_pend1_clr", 32'(pend[1]), 32'd0);
            adv();
        end

        // Back to period 8 on ch1.
        ld  = 2'b10;
        div = 8'h80;
        #1;
        check_val("p8_tick1_ld", 32'(tick[1]), 32'd1);
        adv();
        ld = 2'b00;
        #1;
        check_val("p8_tick1_last", 32'(tick[1]), 32'd1);
        check_val("p8_pend1", 32'(pend[1]), 32'd1);
        adv();
        while (cyc <= 72) begin
            #1;
            check_val("p8_tick1", 32'(tick[1]), 32'd0);
            adv();
        end

        // ch0 load of 5 in its own wrap cycle: switch keeps old shadow (3).
        ld  = 2'b01;
        div = 8'h05;
        #1;
        check_val("sw_ld_tick0", 32'(tick[0]), 32'd1);
        adv();
        ld = 2'b00;
        #1;
        check_val("sw_ld_pend0", 32'(pend[0]), 32'd1);
        adv();
        adv();

        // sync_clr in a ch0 wrap cycle: tick suppressed, pending 5 applied.
        sync_clr = 1'b1;
        #1;
        check_val("clr_tick", 32'(tick), 32'd0);
        check_val("clr_pend", 32'(pend), 32'd1);
        adv();
        sync_clr = 1'b0;
        while (cyc <= 85) begin
            if (cyc == 85) begin
                ld  = 2'b01;
                div = 8'h02;
            end
            #1;
            check_val("clr_tick0", 32'(tick[0]), 32'(((cyc - 77) % 5) == 4));
            check_val("clr_tick1", 32'(tick[1]), 32'(((cyc - 77) % 8) == 7));
            check_val("clr_sq0",   32'(sq[0]),   32'(((cyc - 77) % 5) >= 2));
            check_val("clr_sq1",   32'(sq[1]),   32'(((cyc - 77) % 8) >= 4));
            check_val("clr_pend",  32'(pend),    32'd0);
            adv();
        end
        ld = 2'b00;

        // Reset in a ch0 wrap cycle with a pending load.
        n_rst = 1'b0;
        #1;
        check_val("mrst_tick", 32'(tick), 32'd0);
        check_val("mrst_pend", 32'(pend), 32'd1);
        check_val("mrst_sq",   32'(sq),   32'd1);
        adv();
        n_rst = 1'b1;
        while (cyc <= 96) begin
            #1;
            check_val("post_tick", 32'(tick), 32'({2{((cyc - 87) % 8) == 7}}));
            check_val("post_sq",   32'(sq),   32'({2{((cyc - 87) % 8) >= 4}}));
            check_val("post_pend", 32'(pend), 32'd0);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
